dev_bus_arbiter: RTL and testbench
==================================

# dev_bus_arbiter

Two-master arbiter placed in front of the device bridge, sharing its single processor-side port between the CPU data port (master 0) and a DMA/debug master (master 1). Each granted request becomes exactly one registered bridge cycle, and the arbiter returns a registered response. Requests outside the device windows complete with an error and never reach the bridge. Fairness is strict two-way round-robin.

## Interface
Parameters:
- DEV_BASE, 32'h0000_7f00, lowest decoded device address
- DEV_LIMIT, 32'h0000_7f1b, highest decoded device address (inclusive)

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset; asynchronous, active-low
- M0Req, M1Req  in  1  request; held with a stable command until the matching Ack
- M0Addr, M1Addr  in  32  byte address
- M0WData, M1WData  in  32  write data
- M0Mask, M1Mask  in  4  byte-enable
- M0Write, M1Write  in  1  1 = write, 0 = read
- M0Ack, M1Ack  out  1  one-cycle completion pulse
- RspRData  out  32  read data; valid only while an Ack is high
- RspErr  out  1  out-of-window flag; valid only while an Ack is high
- PrAddr  out  32  bridge address
- PrWData  out  32  bridge write data
- PrMask  out  4  bridge byte-enable
- PrWrite  out  1  bridge write strobe
- PrRData  in  32  bridge read data; combinational on PrAddr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No Req: stay in IDLE.
  - One Req: grant that master regardless of the pointer.
  - Both Req: grant the master selected by the pointer `Prio` (0 = M0 first).
  - On a grant: register that master's Addr/WData/Mask/Write into the command register, set `Prio` to the other master, go to ACCESS.
- ACCESS:
  - Window check: DEV_BASE <= Addr <= DEV_LIMIT, unsigned 32-bit compare.
  - In-window: drive Pr* from the command register. PrWrite = registered Write for this cycle only. Capture PrRData into RspRData at the end of the cycle (write transactions capture it as well; value unspecified to the master).
  - Out-of-window: PrWrite stays 0, RspRData captures 0, RspErr captures 1.
  - Always go to RESP.
- RESP: pulse the granted master's Ack for one cycle, then go to IDLE.
- Outside ACCESS: PrWrite = 0; PrAddr/PrWData/PrMask hold their last values.
- The other master's Req is ignored until IDLE and is never dropped. Worst-case wait is one foreign transaction (3 cycles).
- A master that keeps Req high through the cycle after its Ack issues a new request, and competes under the updated `Prio`.
- M0Ack and M1Ack are never high together.

## Timing
- Req first sampled high in IDLE at edge N:
  - ACCESS during cycle N+1 (PrWrite high for an in-window write).
  - RESP during cycle N+2: Ack high; RspRData and RspErr valid.
  - IDLE again at N+3.
- Fixed latency: 3 cycles from Req sampled to IDLE. Peak throughput: one transaction per 3 cycles.
- Reset values: state IDLE, Prio 0, M0Ack/M1Ack 0, RspRData 0, RspErr 0, PrAddr 0, PrWData 0, PrMask 0, PrWrite 0.
- Reset asserted mid-operation (ACCESS or RESP):
  - PrWrite and Ack drop immediately, without waiting for a clock.
  - No Ack is issued for the aborted transaction.
  - After release, arbitration restarts with Prio 0.

## Structure
- Package `dev_bus_pkg`:
  - state enum {IDLE, ACCESS, RESP}.
  - Default DEV_BASE/DEV_LIMIT constants.
  - Per-timer window constants (0x7f00–0x7f0b, 0x7f10–0x7f1b) for reuse by decode logic.
- Sub-module `rr_arbiter2`: inputs Req[1:0] and Prio; outputs one-hot Gnt[1:0] and next Prio. Purely combinational; the Prio register stays in the parent.
- Parent holds the FSM, command register and response register.

## Test plan
- M0 write to 0x7f04, WData 0x0000_0010, Mask 4'hf: PrWrite high exactly one cycle with PrAddr 0x7f04; M0Ack 2 cycles after grant; RspErr 0.
- M1 read 0x7f18 while bridge model returns 0xdead_beef: M1Ack with RspRData 0xdead_beef; M0Ack stays 0.
- Both Req continuously from reset: grants alternate M0, M1, M0, M1; Acks spaced 3 cycles apart.
- M0 read 0x0000_1000: no PrWrite pulse; M0Ack with RspErr 1, RspRData 0.
- Boundary addresses:
  - 0x7f1b: in window; RspErr 0.
  - 0x7f1c: out of window; RspErr 1.
- Rst low during an M1 write's ACCESS cycle: PrWrite falls asynchronously; no M1Ack. After release with both Req high, M0 is granted first.

Source files
------------

// File: rtl/dev_bus_arbiter_pkg.sv
// dev_bus_pkg: shared types and constants for the device-bus arbiter slice.
//   busState_e  - arbiter FSM states (IDLE, ACCESS, RESP)
//   busCmd_t    - command register captured at grant time
//   DEV_*       - default decoded device window
//   TIMERn_*    - per-timer sub-windows inside the device window
//   inWindow()  - inclusive unsigned window compare
package dev_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } busState_e;

    localparam logic [31:0] DEV_BASE_DEFAULT  = 32'h0000_7f00;
    localparam logic [31:0] DEV_LIMIT_DEFAULT = 32'h0000_7f1b;

    localparam logic [31:0] TIMER0_BASE  = 32'h0000_7f00;
    localparam logic [31:0] TIMER0_LIMIT = 32'h0000_7f0b;
    localparam logic [31:0] TIMER1_BASE  = 32'h0000_7f10;
    localparam logic [31:0] TIMER1_LIMIT = 32'h0000_7f1b;

    // The write bit of a command lives in the bridge strobe register,
    // already qualified by the window check, so it is not duplicated here.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wData;
        logic [3:0]  mask;
        logic        inWin;
        logic        owner;   // 0 = master 0, 1 = master 1
    } busCmd_t;

    function automatic logic inWindow(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// dev_bus_arbiter_if: bundles both master ports, the shared response and
// the processor-side bridge port.
//   slave  modport - used by the arbiter (masters' commands in, acks out,
//                    bridge command out, bridge read data in)
//   master modport - used by whatever drives the masters and models the bridge
interface dev_bus_arbiter_if;

    logic        M0Req;
    logic [31:0] M0Addr;
    logic [31:0] M0WData;
    logic [3:0]  M0Mask;
    logic        M0Write;
    logic        M0Ack;

    logic        M1Req;
    logic [31:0] M1Addr;
    logic [31:0] M1WData;
    logic [3:0]  M1Mask;
    logic        M1Write;
    logic        M1Ack;

    logic [31:0] RspRData;
    logic        RspErr;

    logic [31:0] PrAddr;
    logic [31:0] PrWData;
    logic [3:0]  PrMask;
    logic        PrWrite;
    logic [31:0] PrRData;

    modport slave (
        input  M0Req, M0Addr, M0WData, M0Mask, M0Write,
        input  M1Req, M1Addr, M1WData, M1Mask, M1Write,
        input  PrRData,
        output M0Ack, M1Ack, RspRData, RspErr,
        output PrAddr, PrWData, PrMask, PrWrite
    );

    modport master (
        output M0Req, M0Addr, M0WData, M0Mask, M0Write,
        output M1Req, M1Addr, M1WData, M1Mask, M1Write,
        output PrRData,
        input  M0Ack, M1Ack, RspRData, RspErr,
        input  PrAddr, PrWData, PrMask, PrWrite
    );

endinterface

// File: rtl/dev_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   Req[1:0]  - request vector (bit n = master n)
//   Prio      - pointer, 0 = master 0 wins a tie
//   Gnt[1:0]  - one-hot grant (zero when nobody requests)
//   PrioNext  - pointer value after this grant (the other master)
module rr_arbiter2 (
    input  logic [1:0] Req,
    input  logic       Prio,
    output logic [1:0] Gnt,
    output logic       PrioNext
);

    // Grant a lone requester outright; on a tie the pointer decides.
    always_comb begin
        Gnt      = 2'b00;
        PrioNext = Prio;
        case (Req)
            2'b01: begin
                Gnt      = 2'b01;
                PrioNext = 1'b1;
            end
            2'b10: begin
                Gnt      = 2'b10;
                PrioNext = 1'b0;
            end
            2'b11: begin
                if (Prio) begin
                    Gnt      = 2'b10;
                    PrioNext = 1'b0;
                end else begin
                    Gnt      = 2'b01;
                    PrioNext = 1'b1;
                end
            end
            default: begin
                Gnt      = 2'b00;
                PrioNext = Prio;
            end
        endcase
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: shares the device bridge port between master 0 (CPU) and
// master 1 (DMA/debug). Each grant becomes one registered bridge cycle
// followed by a one-cycle Ack with registered response data.
//   Clk  - rising-edge clock
//   Rst  - asynchronous active-low reset
//   bus  - dev_bus_arbiter_if.slave: master commands/acks, response, bridge
// Parameters DEV_BASE/DEV_LIMIT bound the decoded window (inclusive).
module dev_bus_arbiter
    import dev_bus_pkg::*;
#(
    parameter logic [31:0] DEV_BASE  = DEV_BASE_DEFAULT,
    parameter logic [31:0] DEV_LIMIT = DEV_LIMIT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    dev_bus_arbiter_if.slave bus
);

    busState_e   stateR;
    busState_e   stateNextS;
    logic        prioR;
    busCmd_t     cmdR;
    logic [1:0]  ackR;
    logic        prWriteR;
    logic [31:0] rspRDataR;
    logic        rspErrR;

    logic [1:0]  reqS;
    logic [1:0]  gntS;
    logic        prioNextS;
    logic [31:0] selAddrS;
    logic [31:0] selWDataS;
    logic [3:0]  selMaskS;
    logic        selWriteS;
    logic        selInWinS;

    logic        grantS;
    logic        captureS;
    logic [1:0]  ackNextS;
    logic        prWriteNextS;

    assign reqS = {bus.M1Req, bus.M0Req};

    rr_arbiter2 uArb (
        .Req      (reqS),
        .Prio     (prioR),
        .Gnt      (gntS),
        .PrioNext (prioNextS)
    );

    // Steer the granted master's command toward the command register.
    always_comb begin
        if (gntS[1]) begin
            selAddrS  = bus.M1Addr;
            selWDataS = bus.M1WData;
            selMaskS  = bus.M1Mask;
            selWriteS = bus.M1Write;
        end else begin
            selAddrS  = bus.M0Addr;
            selWDataS = bus.M0WData;
            selMaskS  = bus.M0Mask;
            selWriteS = bus.M0Write;
        end
        selInWinS = inWindow(selAddrS, DEV_BASE, DEV_LIMIT);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // FSM next-state logic: every grant walks IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            IDLE: begin
                if (reqS != 2'b00) begin
                    stateNextS = ACCESS;
                end else begin
                    stateNextS = IDLE;
                end
            end
            ACCESS:  stateNextS = RESP;
            RESP:    stateNextS = IDLE;
            default: stateNextS = IDLE;
        endcase
    end

    // FSM output decode: load enables and next values for the output registers.
    // The strobe and acks are computed one state early so that the registers
    // present them during ACCESS and RESP respectively.
    always_comb begin
        grantS       = 1'b0;
        captureS     = 1'b0;
        ackNextS     = 2'b00;
        prWriteNextS = 1'b0;
        case (stateR)
            IDLE: begin
                grantS       = (gntS != 2'b00);
                prWriteNextS = grantS & selWriteS & selInWinS;
            end
            ACCESS: begin
                captureS = 1'b1;
                ackNextS = cmdR.owner ? 2'b10 : 2'b01;
            end
            RESP: begin
                captureS = 1'b0;
            end
            default: begin
                grantS = 1'b0;
            end
        endcase
    end

    // Round-robin pointer: moves to the other master after each grant.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prioR <= 1'b0;
        end else if (grantS) begin
            prioR <= prioNextS;
        end else begin
            prioR <= prioR;
        end
    end

    // Command register: loaded only on a grant, so the bridge address,
    // data and mask hold their last values between transactions.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cmdR <= '0;
        end else if (grantS) begin
            cmdR.addr  <= selAddrS;
            cmdR.wData <= selWDataS;
            cmdR.mask  <= selMaskS;
            cmdR.inWin <= selInWinS;
            cmdR.owner <= gntS[1];
        end else begin
            cmdR <= cmdR;
        end
    end

    // Bridge write strobe and master acks; async reset drops both at once.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prWriteR <= 1'b0;
            ackR     <= 2'b00;
        end else begin
            prWriteR <= prWriteNextS;
            ackR     <= ackNextS;
        end
    end

    // Response register: sampled at the end of ACCESS; out-of-window
    // requests return zero data with the error flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rspRDataR <= 32'h0000_0000;
            rspErrR   <= 1'b0;
        end else if (captureS) begin
            rspRDataR <= cmdR.inWin ? bus.PrRData : 32'h0000_0000;
            rspErrR   <= ~cmdR.inWin;
        end else begin
            rspRDataR <= rspRDataR;
            rspErrR   <= rspErrR;
        end
    end

    assign bus.M0Ack    = ackR[0];
    assign bus.M1Ack    = ackR[1];
    assign bus.RspRData = rspRDataR;
    assign bus.RspErr   = rspErrR;
    assign bus.PrAddr   = cmdR.addr;
    assign bus.PrWData  = cmdR.wData;
    assign bus.PrMask   = cmdR.mask;
    assign bus.PrWrite  = prWriteR;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Scoreboard bench for dev_bus_arbiter: drivers push the expected response
// of every request into a per-master queue; a negedge monitor pops and
// compares whenever an Ack appears, and checks round-robin order from the
// request vector seen at the arbitration edge.
module tb_dev_bus_arbiter;

    localparam logic [31:0] WIN_LO = 32'h0000_7f00;
    localparam logic [31:0] WIN_HI = 32'h0000_7f1b;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  mask  [2];
    logic        wr    [2];

    exp_t expQ0[$];
    exp_t expQ1[$];

    always #5 Clk = ~Clk;

    dev_bus_arbiter_if bus();

    dev_bus_arbiter #(
        .DEV_BASE  (32'h0000_7f00),
        .DEV_LIMIT (32'h0000_7f1b)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Bridge model: fixed pattern per address, with one special register.
    function automatic logic [31:0] bridgeData(input logic [31:0] a);
        if (a == 32'h0000_7f18) return 32'hdead_beef;
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    assign bus.M0Req   = req[0];
    assign bus.M0Addr  = addr[0];
    assign bus.M0WData = wdata[0];
    assign bus.M0Mask  = mask[0];
    assign bus.M0Write = wr[0];
    assign bus.M1Req   = req[1];
    assign bus.M1Addr  = addr[1];
    assign bus.M1WData = wdata[1];
    assign bus.M1Mask  = mask[1];
    assign bus.M1Write = wr[1];
    assign bus.PrRData = bridgeData(bus.PrAddr);

    function automatic logic ackOf(input int m);
        return (m == 0) ? bus.M0Ack : bus.M1Ack;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge Clk) cycle <= cycle + 1;

    // Request vector seen at the last two rising edges.
    logic [1:0] reqP1 = 2'b00;
    logic [1:0] reqP2 = 2'b00;
    always @(posedge Clk) begin
        reqP2 <= reqP1;
        reqP1 <= {bus.M1Req, bus.M0Req};
    end

    // Monitor / scoreboard.
    initial begin
        logic        modelPrio;
        logic        prevPrWrite;
        logic [31:0] prevPrAddr;
        logic [31:0] prevPrWData;
        logic [3:0]  prevPrMask;
        exp_t        e;
        modelPrio   = 1'b0;
        prevPrWrite = 1'b0;
        prevPrAddr  = 32'h0;
        prevPrWData = 32'h0;
        prevPrMask  = 4'h0;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                modelPrio   = 1'b0;
                prevPrWrite = 1'b0;
            end else begin
                if (bus.M0Ack && bus.M1Ack) begin
                    chk("acks_exclusive", {30'h0, bus.M1Ack, bus.M0Ack}, 32'h1);
                end
                if (prevPrWrite) chk("prwrite_one_cycle", {31'h0, bus.PrWrite}, 32'h0);
                for (int m = 0; m < 2; m++) begin
                    if (ackOf(m)) begin
                        if ((m == 0 && expQ0.size() == 0) || (m == 1 && expQ1.size() == 0)) begin
                            chk($sformatf("unexpected_ack_m%0d", m), 32'h1, 32'h0);
                        end else begin
                            e = (m == 0) ? expQ0.pop_front() : expQ1.pop_front();
                            chk($sformatf("rsp_err_m%0d_a%h", m, e.addr), {31'h0, bus.RspErr}, {31'h0, e.err});
                            if (!e.write)
                                chk($sformatf("rsp_rdata_m%0d_a%h", m, e.addr), bus.RspRData, e.rdata);
                            if (e.write && !e.err) begin
                                chk("prwrite_pulse", {31'h0, prevPrWrite}, 32'h1);
                                chk("praddr", prevPrAddr, e.addr);
                                chk("prwdata", prevPrWData, e.wdata);
                                chk("prmask", {28'h0, prevPrMask}, {28'h0, e.mask});
                            end else begin
                                chk($sformatf("no_prwrite_a%h", e.addr), {31'h0, prevPrWrite}, 32'h0);
                            end
                            chk("req_at_grant", {31'h0, reqP2[m]}, 32'h1);
                            if (reqP2 == 2'b11)
                                chk("rr_winner", m, {31'h0, modelPrio});
                            modelPrio = (m == 0);
                        end
                    end
                end
                prevPrWrite = bus.PrWrite;
                prevPrAddr  = bus.PrAddr;
                prevPrWData = bus.PrWData;
                prevPrMask  = bus.PrMask;
            end
        end
    end

    // Issue one request, record its expected response, wait for the Ack.
    task automatic issue(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] k, output int waited);
        exp_t e;
        bit   got;
        e.write = w;
        e.addr  = a;
        e.wdata = d;
        e.mask  = k;
        e.err   = (a < WIN_LO) || (a > WIN_HI);
        e.rdata = e.err ? 32'h0 : bridgeData(a);
        if (m == 0) expQ0.push_back(e); else expQ1.push_back(e);
        wr[m]    = w;
        addr[m]  = a;
        wdata[m] = d;
        mask[m]  = k;
        req[m]   = 1'b1;
        got      = 1'b0;
        waited   = 0;
        while (!got && waited < 30) begin
            @(negedge Clk);
            waited++;
            if (ackOf(m)) got = 1'b1;
        end
        if (!got) begin
            chk($sformatf("ack_timeout_m%0d", m), 32'h0, 32'h1);
            if (m == 0) void'(expQ0.pop_back()); else void'(expQ1.pop_back());
        end
        req[m] = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 5))
            0:       return WIN_LO + 32'($urandom_range(0, 27));
            1:       return 32'h0000_7f1b;
            2:       return 32'h0000_7f1c;
            3:       return 32'h0000_7eff;
            4:       return 32'($urandom);
            default: return WIN_LO + 32'($urandom_range(0, 27));
        endcase
    endfunction

    task automatic masterLoop(input int m, input int n, input int maxGap);
        int w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxGap)) @(negedge Clk);
            issue(m, 1'($urandom_range(0, 1)), randAddr(), 32'($urandom),
                  4'($urandom_range(0, 15)), w);
        end
    endtask

    // With both masters saturating, Acks alternate M0,M1,... three cycles apart.
    task automatic altCheck(input int n);
        int lastCyc = 0;
        for (int k = 0; k < n; k++) begin
            bit got = 1'b0;
            int who = -1;
            for (int t = 0; t < 12 && !got; t++) begin
                @(negedge Clk);
                if (bus.M0Ack) begin got = 1'b1; who = 0; end
                else if (bus.M1Ack) begin got = 1'b1; who = 1; end
            end
            if (!got) begin
                chk("alt_ack_timeout", 32'h0, 32'h1);
            end else begin
                chk($sformatf("alt_master_%0d", k), who, k % 2);
                if (k > 0) chk("ack_spacing", cycle - lastCyc, 32'd3);
                lastCyc = cycle;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dAddr  [8];
        logic        dWr    [8];
        int          dM     [8];
        int          w;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; mask[i] = 4'h0; wr[i] = 1'b0;
        end

        // Reset values.
        @(negedge Clk);
        chk("rst_m0ack",    {31'h0, bus.M0Ack},   32'h0);
        chk("rst_m1ack",    {31'h0, bus.M1Ack},   32'h0);
        chk("rst_rdata",    bus.RspRData,         32'h0);
        chk("rst_err",      {31'h0, bus.RspErr},  32'h0);
        chk("rst_praddr",   bus.PrAddr,           32'h0);
        chk("rst_prwdata",  bus.PrWData,          32'h0);
        chk("rst_prmask",   {28'h0, bus.PrMask},  32'h0);
        chk("rst_prwrite",  {31'h0, bus.PrWrite}, 32'h0);
        #2 Rst = 1'b1;

        // Both masters requesting continuously from reset.
        @(negedge Clk);
        fork
            masterLoop(0, 4, 0);
            masterLoop(1, 4, 0);
            altCheck(8);
        join
        repeat (2) @(negedge Clk);

        // Directed: window hits, the 0xdeadbeef register, misses, boundaries.
        dM[0] = 0; dWr[0] = 1'b1; dAddr[0] = 32'h0000_7f04;
        dM[1] = 1; dWr[1] = 1'b0; dAddr[1] = 32'h0000_7f18;
        dM[2] = 0; dWr[2] = 1'b0; dAddr[2] = 32'h0000_1000;
        dM[3] = 0; dWr[3] = 1'b0; dAddr[3] = 32'h0000_7f1b;
        dM[4] = 1; dWr[4] = 1'b0; dAddr[4] = 32'h0000_7f1c;
        dM[5] = 1; dWr[5] = 1'b1; dAddr[5] = 32'h0000_7f1c;
        dM[6] = 0; dWr[6] = 1'b0; dAddr[6] = 32'h0000_7f00;
        dM[7] = 1; dWr[7] = 1'b1; dAddr[7] = 32'h0000_7eff;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            issue(dM[i], dWr[i], dAddr[i], 32'h0000_0010 + 32'(i), 4'hf, w);
            chk($sformatf("latency_%0d", i), w, 32'd2);
        end
        repeat (2) @(negedge Clk);

        // Randomised traffic from both masters.
        fork
            masterLoop(0, 40, 3);
            masterLoop(1, 40, 3);
        join
        repeat (3) @(negedge Clk);

        // Reset during an M1 write's ACCESS cycle.
        wr[1] = 1'b1; addr[1] = 32'h0000_7f08; wdata[1] = 32'h1234_5678; mask[1] = 4'hf;
        req[1] = 1'b1;
        @(negedge Clk);
        chk("abort_prwrite_before", {31'h0, bus.PrWrite}, 32'h1);
        #2 Rst = 1'b0;
        #1;
        chk("abort_prwrite_async", {31'h0, bus.PrWrite}, 32'h0);
        chk("abort_m1ack",         {31'h0, bus.M1Ack},   32'h0);
        req[1] = 1'b0;
        @(negedge Clk);
        chk("abort_m1ack_later",   {31'h0, bus.M1Ack},   32'h0);
        chk("abort_err",           {31'h0, bus.RspErr},  32'h0);
        chk("abort_praddr",        bus.PrAddr,           32'h0);
        #2 Rst = 1'b1;
        @(negedge Clk);
        fork
            masterLoop(0, 2, 0);
            masterLoop(1, 2, 0);
            altCheck(4);
        join
        repeat (3) @(negedge Clk);
        chk("queue0_drained", expQ0.size(), 32'h0);
        chk("queue1_drained", expQ1.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
